// File: rtl/conv_window_ctrl.sv
// Sliding-window controller: accepts a raster-scanned frame, drives the line-buffer shift enable
// and flags complete kernelSize x kernelSize windows. Define CONV_STRIDE2_EN for stride-2 output.
module conv_window_ctrl #(
    parameter int dataWidth  = 16,
    parameter int imgWidth   = 28,
    parameter int imgHeight  = 28,
    parameter int kernelSize = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    input  logic [dataWidth-1:0]         in_data,
    output logic                         in_ready,
    input  logic                         out_ready,
    output logic                         shift_ce,
    output logic [dataWidth-1:0]         shift_data,
    output logic                         win_valid,
    output logic [$clog2(imgWidth)-1:0]  col,
    output logic [$clog2(imgHeight)-1:0] row,
    output logic [15:0]                  win_cnt,
    output logic                         busy,
    output logic                         done
);

    localparam int CW = $clog2(imgWidth);
    localparam int RW = $clog2(imgHeight);
    localparam logic [CW-1:0] COL_LAST = CW'(imgWidth - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(imgHeight - 1);
    localparam logic [CW-1:0] COL_K    = CW'(kernelSize - 1);
    localparam logic [RW-1:0] ROW_K    = RW'(kernelSize - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [15:0]   win_cnt_q, win_cnt_d;
    logic          win_valid_q, win_valid_d;

    logic          accept;
    logic          win_hit;
    logic [CW-1:0] col_off;
    logic [RW-1:0] row_off;

    assign in_ready   = (state_q == RUN) && out_ready;
    assign accept     = in_valid && in_ready;
    assign shift_ce   = accept;
    assign shift_data = in_data;

    // Offsets into the valid region; only their LSB matters for the stride-2 phase test.
    assign col_off = col_q - COL_K;
    assign row_off = row_q - ROW_K;

`ifdef CONV_STRIDE2_EN
    assign win_hit = (row_q >= ROW_K) && (col_q >= COL_K) && !row_off[0] && !col_off[0];
`else
    assign win_hit = (row_q >= ROW_K) && (col_q >= COL_K);
`endif

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        win_cnt_d   = win_cnt_q;
        win_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = RUN;
                    col_d     = '0;
                    row_d     = '0;
                    win_cnt_d = '0;
                end
            end
            RUN: begin
                if (accept) begin
                    win_valid_d = win_hit;
                    if (win_hit) begin
                        win_cnt_d = win_cnt_q + 16'd1;
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            row_d   = '0;
                            state_d = DONE;
                        end else begin
                            row_d = row_q + RW'(1);
                        end
                    end else begin
                        col_d = col_q + CW'(1);
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            col_q       <= '0;
            row_q       <= '0;
            win_cnt_q   <= '0;
            win_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            win_cnt_q   <= win_cnt_d;
            win_valid_q <= win_valid_d;
        end
    end

    assign col       = col_q;
    assign row       = row_q;
    assign win_cnt   = win_cnt_q;
    assign win_valid = win_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: doc/conv_window_ctrl.md
CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

Interface
REQ-001 SHALL have parameter dataWidth, default 16, pixel width (pass-through only).
REQ-002 SHALL have parameter imgWidth, default 28, pixels per row (>= kernelSize).
REQ-003 SHALL have parameter imgHeight, default 28, rows per frame (>= kernelSize).
REQ-004 SHALL have parameter kernelSize, default 3, window edge; line-buffer depth is imgWidth.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse, begins a frame.
REQ-008 SHALL have port in_valid  input  1  upstream pixel available.
REQ-009 SHALL have port in_data  input  dataWidth  upstream pixel.
REQ-010 SHALL have port in_ready  output  1  pixel accepted when in_valid && in_ready.
REQ-011 SHALL have port out_ready  input  1  downstream MAC array can take a window.
REQ-012 SHALL have port shift_ce  output  1  clock enable to every line-buffer/window shift register.
REQ-013 SHALL have port shift_data  output  dataWidth  data_in for the first shift register.
REQ-014 SHALL have port win_valid  output  1  window registers hold a complete window.
REQ-015 SHALL have port col, row  output  $clog2(imgWidth), $clog2(imgHeight)  position of next pixel.
REQ-016 SHALL have port win_cnt  output  16  windows emitted this frame.
REQ-017 SHALL have ports busy, done  output  1 each  frame in progress; one-cycle end pulse.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on start, RUN->DONE after last pixel accepted, DONE->IDLE unconditionally next cycle.
REQ-019 SHALL ignore start while in RUN or DONE.
REQ-020 SHALL drive in_ready = (state==RUN) && out_ready, combinationally.
REQ-021 SHALL drive shift_ce = in_valid && in_ready and shift_data = in_data, combinationally, zero added latency.
REQ-022 SHALL advance col on every accepted pixel; col==imgWidth-1 wraps to 0 and increments row.
REQ-023 SHALL treat the accepted pixel at row==imgHeight-1, col==imgWidth-1 as last; row and col return to 0 on it.
REQ-024 SHALL register win_valid high for exactly one cycle following acceptance of a pixel with row>=kernelSize-1 and col>=kernelSize-1 (latency 1), else low.
REQ-025 SHALL increment win_cnt in the same cycle win_valid asserts; win_cnt clears to 0 on start accepted in IDLE.
REQ-026 SHALL hold counters, win_valid low and shift_ce low on cycles with no acceptance (in_valid low or out_ready low).
REQ-027 SHALL assert busy in RUN and DONE; done high only in DONE.
REQ-028 SHALL emit (imgHeight-kernelSize+1)*(imgWidth-kernelSize+1) windows per frame, stride 1.

Reset
REQ-029 SHALL on rst low, immediately and asynchronously: state IDLE, row=0, col=0, win_cnt=0, win_valid=0, done=0, busy=0.
REQ-030 SHALL abandon a frame on reset mid-RUN; no done pulse; next frame requires a new start.
REQ-031 SHALL not reset the external shift registers; stale contents are never flagged valid, since win_valid requires kernelSize-1 fresh rows.

Configuration
REQ-032 SHALL, with macro CONV_STRIDE2_EN defined, additionally require (row-(kernelSize-1)) and (col-(kernelSize-1)) both even for win_valid, giving ceil-halved window counts.
REQ-033 SHALL, without CONV_STRIDE2_EN, behave as stride 1 per REQ-024 and REQ-028; shifting and counters are identical in both builds.

Verification (imgWidth=5, imgHeight=5, kernelSize=3)
REQ-034 SHALL check: start, in_valid and out_ready held high, 25 pixels -> first win_valid the cycle after pixel 13 (row 2, col 2); 9 windows; win_cnt=9; done pulses once; then IDLE.
REQ-035 SHALL check: out_ready low for 4 cycles mid-row -> in_ready and shift_ce low, row/col/win_cnt frozen; final win_cnt still 9.
REQ-036 SHALL check: in_valid toggled randomly 50% -> shift_ce count = 25, win_cnt = 9, no win_valid without preceding acceptance.
REQ-037 SHALL check: start pulsed again during RUN -> ignored, counters uninterrupted.
REQ-038 SHALL check: rst asserted after pixel 10 -> all outputs to reset values same cycle; new start gives full 9-window frame.
REQ-039 SHALL check: CONV_STRIDE2_EN build, full frame -> 4 windows at (row,col) = (2,2),(2,4),(4,2),(4,4); win_cnt=4.
